// File: rtl/branch_history_unit.sv
// Branch predictor front stage: tagged per-PC local history table plus an in-flight FIFO
// that feeds resolved outcomes back as a one-cycle update bundle. Optional macro: HIST_BYPASS_EN.
module branch_history_unit #(
  parameter int PC_WIDTH    = 10,
  parameter int ENTRY_WIDTH = 4,
  parameter int HIST_WIDTH  = 3,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          lookup_valid,
  input  logic [PC_WIDTH-1:0]           lookup_pc,
  output logic                          lookup_ready,
  output logic [HIST_WIDTH-1:0]         prev_history,
  output logic                          evict,
  input  logic                          resolve_valid,
  input  logic                          resolve_taken,
  input  logic                          flush,
  output logic                          we,
  output logic [PC_WIDTH-1:0]           old_pc,
  output logic [HIST_WIDTH-1:0]         update_history,
  output logic                          branch_taken,
  output logic [$clog2(FIFO_DEPTH):0]   inflight_count
);
  localparam int DEPTH = 1 << ENTRY_WIDTH;
  localparam int TAG_W = PC_WIDTH - ENTRY_WIDTH;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0]                 tbl_valid;
  logic [DEPTH-1:0][TAG_W-1:0]      tbl_tag;
  logic [DEPTH-1:0][HIST_WIDTH-1:0] tbl_hist;

  logic [FIFO_DEPTH-1:0][PC_WIDTH-1:0]   fifo_pc;
  logic [FIFO_DEPTH-1:0][HIST_WIDTH-1:0] fifo_hist;
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;

  logic [ENTRY_WIDTH-1:0] l_idx, r_idx;
  logic [TAG_W-1:0]       l_tag, r_tag;
  logic [PC_WIDTH-1:0]    head_pc;
  logic [HIST_WIDTH-1:0]  head_hist, shifted;
  logic hit, full, accept, install, pop, r_match, upd;

  always_comb begin
    l_idx   = lookup_pc[ENTRY_WIDTH-1:0];
    l_tag   = lookup_pc[PC_WIDTH-1:ENTRY_WIDTH];
    hit     = tbl_valid[l_idx] && (tbl_tag[l_idx] == l_tag);
    full    = (count == CNT_W'(FIFO_DEPTH));
    lookup_ready = !full && !flush;
    accept  = lookup_valid && lookup_ready;
    install = accept && !hit;
    evict   = install;

    head_pc   = fifo_pc[rd_ptr];
    head_hist = fifo_hist[rd_ptr];
    r_idx     = head_pc[ENTRY_WIDTH-1:0];
    r_tag     = head_pc[PC_WIDTH-1:ENTRY_WIDTH];
    pop       = resolve_valid && (count != '0);
    r_match   = tbl_valid[r_idx] && (tbl_tag[r_idx] == r_tag);
    // A same-edge install into the resolving slot means the resolving branch was evicted.
    upd       = pop && r_match && !(install && (l_idx == r_idx));
    shifted   = {tbl_hist[r_idx][HIST_WIDTH-2:0], resolve_taken};

    prev_history = '0;
    if (hit) begin
`ifdef HIST_BYPASS_EN
      // hit excludes install, so upd here is the plain resolve qualifier (no loop).
      if (upd && (l_idx == r_idx)) prev_history = shifted;
      else                         prev_history = tbl_hist[l_idx];
`else
      prev_history = tbl_hist[l_idx];
`endif
    end
  end

  assign inflight_count = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl_valid <= '0;
      tbl_tag   <= '0;
      tbl_hist  <= '0;
    end else begin
      if (upd) tbl_hist[r_idx] <= shifted;
      if (install) begin
        tbl_valid[l_idx] <= 1'b1;
        tbl_tag[l_idx]   <= l_tag;
        tbl_hist[l_idx]  <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_pc   <= '0;
      fifo_hist <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
    end else begin
      if (accept) begin
        fifo_pc[wr_ptr]   <= lookup_pc;
        fifo_hist[wr_ptr] <= prev_history;
      end
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (accept) wr_ptr <= wr_ptr + 1'b1;
        if (pop)    rd_ptr <= rd_ptr + 1'b1;
        case ({accept, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // Update bundle: strobe pulses once per applied resolve, payload holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we             <= 1'b0;
      old_pc         <= '0;
      update_history <= '0;
      branch_taken   <= 1'b0;
    end else begin
      we <= upd;
      if (upd) begin
        old_pc         <= head_pc;
        update_history <= head_hist;
        branch_taken   <= resolve_taken;
      end
    end
  end
endmodule

// File: tb/tb_branch_history_unit.sv
// Scoreboard bench for branch_history_unit: behavioural table/FIFO model, expected update
// bundles queued per driven cycle and popped when the registered outputs appear.
module tb_branch_history_unit;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       lookup_valid = 1'b0, resolve_valid = 1'b0, resolve_taken = 1'b0, flush = 1'b0;
  logic [9:0] lookup_pc = '0;
  logic       lookup_ready, evict, we, branch_taken;
  logic [2:0] prev_history, update_history, inflight_count;
  logic [9:0] old_pc;

  always #5 clk = ~clk;

  branch_history_unit dut (
    .clk(clk), .rst_n(rst_n), .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .lookup_ready(lookup_ready), .prev_history(prev_history), .evict(evict),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken), .flush(flush),
    .we(we), .old_pc(old_pc), .update_history(update_history),
    .branch_taken(branch_taken), .inflight_count(inflight_count));

  typedef struct { bit [9:0] pc; bit [2:0] h; } fent_t;
  typedef struct { bit we; bit [9:0] pc; bit [2:0] h; bit t; } upd_t;

  int vectors = 0, miscompares = 0;
  bit       mv [16];
  bit [5:0] mt [16];
  bit [2:0] mh [16];
  fent_t    mq [$];
  upd_t     sb [$];
  bit [9:0] r_pc;
  bit [2:0] r_h;
  bit       r_t;
  logic       obs_evict, obs_ready;
  logic [2:0] obs_ph;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin mv[i] = 0; mt[i] = 0; mh[i] = 0; end
    mq.delete(); sb.delete();
    r_pc = 0; r_h = 0; r_t = 0;
  endtask

  // Called at posedge+1: drive, check comb outputs, advance model, check registered outputs.
  task automatic step(input bit lv, input bit [9:0] lpc, input bit rv, input bit rt, input bit fl);
    int idx, ridx;
    bit hit, rdy, inst, pop, rmatch, upd, acc;
    bit [2:0] ph, sh;
    fent_t head, ne;
    upd_t u;
    lookup_valid = lv; lookup_pc = lpc; resolve_valid = rv; resolve_taken = rt; flush = fl;
    #1;
    idx  = int'(lpc[3:0]);
    hit  = mv[idx] && mt[idx] == lpc[9:4];
    rdy  = (mq.size() < 4) && !fl;
    acc  = lv && rdy;
    inst = acc && !hit;
    ph   = hit ? mh[idx] : 3'b000;
    pop  = rv && mq.size() != 0;
    head = pop ? mq[0] : '{pc: 10'h0, h: 3'h0};
    ridx = int'(head.pc[3:0]);
    rmatch = mv[ridx] && mt[ridx] == head.pc[9:4];
    upd  = pop && rmatch && !(inst && idx == ridx);
    sh   = {mh[ridx][1:0], rt};
`ifdef HIST_BYPASS_EN
    if (hit && upd && idx == ridx) ph = sh;
`endif
    check("lookup_ready", lookup_ready, rdy);
    check("evict", evict, inst);
    check("prev_history", prev_history, ph);
    obs_evict = evict; obs_ready = lookup_ready; obs_ph = prev_history;
    if (pop) void'(mq.pop_front());
    if (upd) mh[ridx] = sh;
    if (inst) begin mv[idx] = 1; mt[idx] = lpc[9:4]; mh[idx] = 0; end
    if (acc) begin ne.pc = lpc; ne.h = ph; mq.push_back(ne); end
    if (fl) mq.delete();
    u.we = upd; u.pc = head.pc; u.h = head.h; u.t = rt;
    sb.push_back(u);
    @(posedge clk); #1;
    u = sb.pop_front();
    if (u.we) begin r_pc = u.pc; r_h = u.h; r_t = u.t; end
    check("we", we, u.we);
    check("old_pc", old_pc, r_pc);
    check("update_history", update_history, r_h);
    check("branch_taken", branch_taken, r_t);
    check("inflight_count", inflight_count, mq.size());
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_we", we, 0);
    check("rst_count", inflight_count, 0);
    check("rst_old_pc", old_pc, 0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_we", we, 0);
    check("reset_old_pc", old_pc, 0);
    check("reset_upd_hist", update_history, 0);
    check("reset_taken", branch_taken, 0);
    check("reset_count", inflight_count, 0);
    check("reset_ready", lookup_ready, 1);
    rst_n = 1'b1;

    // First lookup misses, resolve taken produces the update bundle.
    step(1, 10'h025, 0, 0, 0);
    check("t1_evict", obs_evict, 1);
    check("t1_ph", obs_ph, 0);
    check("t1_count", inflight_count, 1);
    step(0, 10'h000, 1, 1, 0);
    check("t1_we", we, 1);
    check("t1_old_pc", old_pc, 10'h025);
    check("t1_uh", update_history, 0);
    check("t1_bt", branch_taken, 1);
    step(1, 10'h025, 0, 0, 0);
    check("t1_hit_ph", obs_ph, 3'b001);
    step(0, 10'h000, 1, 0, 0);
    do_reset(); // we pulse in flight is killed by reset

    // History sequence T, NT, T.
    step(1, 10'h025, 0, 0, 0); check("t2_ph0", obs_ph, 3'b000);
    step(0, 10'h000, 1, 1, 0);
    step(1, 10'h025, 0, 0, 0); check("t2_ph1", obs_ph, 3'b001);
    step(0, 10'h000, 1, 0, 0);
    step(1, 10'h025, 0, 0, 0); check("t2_ph2", obs_ph, 3'b010);
    step(0, 10'h000, 1, 1, 0);
    step(1, 10'h025, 0, 0, 0); check("t2_ph3", obs_ph, 3'b101);
    step(0, 10'h000, 1, 0, 0);

    // Eviction makes the older in-flight resolve stale.
    step(1, 10'h025, 0, 0, 0);
    step(1, 10'h045, 0, 0, 0); check("t3_evict", obs_evict, 1);
    step(0, 10'h000, 1, 1, 0); check("t3_stale_we", we, 0);
    step(1, 10'h045, 0, 0, 0); check("t3_new_hist", obs_ph, 3'b000);
    step(0, 10'h000, 1, 1, 0);
    step(0, 10'h000, 1, 1, 0);

    // Fill, full backpressure, push+pop across wrap, flush with resolve.
    for (int i = 0; i < 4; i++) step(1, 10'h101 + 10'(i), 0, 0, 0);
    step(1, 10'h105, 0, 0, 0);
    check("t4_full_ready", obs_ready, 0);
    check("t4_full_evict", obs_evict, 0);
    check("t4_full_count", inflight_count, 4);
    step(0, 10'h000, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 10'h111 + 10'(i), 1, i[0], 0);
      check("t4_pp_count", inflight_count, 3);
    end
    step(1, 10'h1aa, 1, 1, 1);
    check("t5_flush_ready", obs_ready, 0);
    check("t5_flush_we", we, 1);
    check("t5_flush_count", inflight_count, 0);

    // Same-cycle hit and resolve on one entry.
    do_reset();
    step(1, 10'h025, 0, 0, 0);
    step(0, 10'h000, 1, 1, 0);
    step(1, 10'h025, 0, 0, 0);
    step(1, 10'h025, 1, 1, 0);
`ifdef HIST_BYPASS_EN
    check("t6_bypass_ph", obs_ph, 3'b011);
`else
    check("t6_nobypass_ph", obs_ph, 3'b001);
`endif
    step(1, 10'h025, 0, 0, 0); check("t6_table", obs_ph, 3'b011);
    // Same-edge install into the resolving slot wins.
    step(1, 10'h045, 1, 1, 0); check("t7_install_we", we, 0);
    for (int i = 0; i < 3; i++) step(0, 10'h000, 1, 0, 0);

    // Random traffic over a few colliding indices/tags.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), {4'h0, 2'($urandom_range(0, 2)), 4'($urandom_range(0, 3))},
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 19) == 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
